// File: rtl/instr_encoder_loader.sv
// Encodes mnemonic requests into {op,arg} words and streams them into imem from base_addr.
// One-entry holding register: accept at N -> mem_we at N+1; in_ready drops while a held write stalls.
module instr_encoder_loader #(
  parameter int INSTR_W = 9,
  parameter int ADDR_W  = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [ADDR_W-1:0]  base_addr,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3:0]         in_kind,
  input  logic [3:0]         in_sub,
  input  logic [INSTR_W-7:0] in_arg,
  input  logic               in_last,
  output logic               mem_we,
  input  logic               mem_ready,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [INSTR_W-1:0] mem_wdata,
  output logic               busy,
  output logic               done,
  output logic               err_illegal,
  output logic               err_full,
  output logic [ADDR_W:0]    words
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE, S_FULL} state_t;

  localparam logic [ADDR_W:0]   CAP      = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   WORD_ONE = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t               state_q, state_d;
  logic                 hold_v_q, hold_v_d;
  logic                 hold_last_q, hold_last_d;
  logic [INSTR_W-1:0]   hold_dat_q, hold_dat_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [ADDR_W:0]      words_q, words_d;
  logic                 err_ill_q, err_ill_d;
  logic                 err_full_q, err_full_d;

  logic [5:0] enc_op;
  logic       enc_ill;
  logic       wr_done, acc, fills;

  always_comb begin
    enc_op  = 6'b000000;
    enc_ill = 1'b0;
    case (in_kind)
      4'd0: enc_op = {3'b000, in_sub[2:0]};
      4'd1: enc_op = 6'b001000;
      4'd2: enc_op = 6'b001001;
      4'd3: enc_op = 6'b001010;
      4'd4: begin
        enc_op  = {2'b01, in_sub};
        // sub[2:0]==101 would alias the BRCI encoding
        enc_ill = (in_sub[2:0] == 3'b101);
      end
      4'd5: enc_op = {2'b01, in_sub[3], 3'b101};
      4'd6: enc_op = {3'b100, in_sub[2:0]};
      4'd7: enc_op = {3'b101, in_sub[2:0]};
      4'd8: enc_op = {3'b110, in_sub[2:0]};
      4'd9: enc_op = {3'b111, in_sub[2:0]};
      default: enc_ill = 1'b1;
    endcase
  end

  assign in_ready    = (state_q == S_LOAD) && (!hold_v_q || mem_ready);
  assign mem_we      = (state_q == S_LOAD) && hold_v_q;
  assign mem_addr    = addr_q;
  assign mem_wdata   = hold_dat_q;
  assign busy        = (state_q == S_LOAD) || (state_q == S_FULL);
  assign done        = (state_q == S_DONE);
  assign err_illegal = err_ill_q;
  assign err_full    = err_full_q;
  assign words       = words_q;

  assign wr_done = mem_we && mem_ready;
  assign acc     = in_valid && in_ready;
  assign fills   = (words_q + WORD_ONE) == CAP;

  always_comb begin
    state_d     = state_q;
    hold_v_d    = hold_v_q;
    hold_last_d = hold_last_q;
    hold_dat_d  = hold_dat_q;
    addr_d      = addr_q;
    words_d     = words_q;
    err_ill_d   = err_ill_q;
    err_full_d  = err_full_q;
    case (state_q)
      S_LOAD: begin
        if (wr_done) begin
          hold_v_d    = 1'b0;
          hold_last_d = 1'b0;
          addr_d      = addr_q + ADDR_ONE;
          words_d     = words_q + WORD_ONE;
          if (hold_last_q) state_d = S_DONE;
          else if (fills)  state_d = S_FULL;
        end
        if (acc) begin
          if (enc_ill) begin
            err_ill_d = 1'b1;
            if (in_last) state_d = S_DONE;
          end else if (wr_done && fills) begin
            // the draining write took the last free slot
            err_full_d = 1'b1;
          end else begin
            hold_v_d    = 1'b1;
            hold_dat_d  = {enc_op, in_arg};
            hold_last_d = in_last;
          end
        end
      end
      S_FULL: if (in_valid) err_full_d = 1'b1;
      default: ;
    endcase
    if (start) begin
      state_d     = S_LOAD;
      hold_v_d    = 1'b0;
      hold_last_d = 1'b0;
      addr_d      = base_addr;
      words_d     = '0;
      err_ill_d   = 1'b0;
      err_full_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      hold_v_q    <= 1'b0;
      hold_last_q <= 1'b0;
      hold_dat_q  <= '0;
      addr_q      <= '0;
      words_q     <= '0;
      err_ill_q   <= 1'b0;
      err_full_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_v_q    <= hold_v_d;
      hold_last_q <= hold_last_d;
      hold_dat_q  <= hold_dat_d;
      addr_q      <= addr_d;
      words_q     <= words_d;
      err_ill_q   <= err_ill_d;
      err_full_q  <= err_full_d;
    end
  end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Bench for instr_encoder_loader: queue-based reference model plus directed literal checks.
module tb_instr_encoder_loader;

  localparam int CAP = 256;

  logic       clk, reset, start, in_valid, in_last, mem_ready;
  logic [7:0] base_addr;
  logic [3:0] in_kind, in_sub;
  logic [2:0] in_arg;
  logic       in_ready, mem_we, busy, done, err_illegal, err_full;
  logic [7:0] mem_addr;
  logic [8:0] mem_wdata, words;

  logic       s_start, s_in_valid, s_in_last, s_mem_ready;
  logic [1:0] s_base;
  logic [3:0] s_in_kind, s_in_sub;
  logic [2:0] s_in_arg;
  logic       s_in_ready, s_mem_we, s_busy, s_done, s_err_illegal, s_err_full;
  logic [1:0] s_mem_addr;
  logic [8:0] s_mem_wdata;
  logic [2:0] s_words;

  int n_tests = 0;
  int n_fail  = 0;
  bit rnd     = 0;

  instr_encoder_loader u_dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind), .in_sub(in_sub),
    .in_arg(in_arg), .in_last(in_last), .mem_we(mem_we), .mem_ready(mem_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .busy(busy), .done(done),
    .err_illegal(err_illegal), .err_full(err_full), .words(words)
  );

  instr_encoder_loader #(.INSTR_W(9), .ADDR_W(2)) u_small (
    .clk(clk), .reset(reset), .start(s_start), .base_addr(s_base),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_kind(s_in_kind), .in_sub(s_in_sub),
    .in_arg(s_in_arg), .in_last(s_in_last), .mem_we(s_mem_we), .mem_ready(s_mem_ready),
    .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata), .busy(s_busy), .done(s_done),
    .err_illegal(s_err_illegal), .err_full(s_err_full), .words(s_words)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit is_illegal(input int k, input int s);
    return (k > 9) || (k == 4 && s % 8 == 5);
  endfunction

  function automatic logic [5:0] model_op(input int k, input int s);
    if (k == 0) return 6'(s % 8);
    if (k <= 3) return 6'(8 + k - 1);
    if (k == 4) return 6'(16 + s);
    if (k == 5) return 6'(16 + (s / 8) * 8 + 5);
    return 6'(32 + (k - 6) * 8 + s % 8);
  endfunction

  function automatic logic [8:0] model_word(input int k, input int s, input int a);
    return {model_op(k, s), 3'(a)};
  endfunction

  typedef struct {
    logic [7:0] addr;
    logic [8:0] data;
    bit         last;
  } wr_t;

  wr_t        exp_q[$];
  bit         m_load = 0, m_done = 0, m_full = 0, m_ei = 0, m_ef = 0;
  int         m_words = 0, m_legal = 0;
  logic [7:0] m_base = 8'h00;
  bit         prev_stall = 0;
  logic [7:0] prev_addr;
  logic [8:0] prev_data;
  logic [7:0] last_wr_addr = 8'h00;
  logic [8:0] last_wr_data = 9'h000;
  logic [1:0] s_addrs[$];

  // Reference model: compare on the falling edge, then advance to the next rising edge.
  always @(negedge clk) begin : mdl
    bit  rdy_e, we_e, wr, acc, go_done, go_full;
    wr_t f;
    rdy_e = m_load && (exp_q.size() == 0 || mem_ready);
    we_e  = m_load && (exp_q.size() != 0);
    chk("in_ready", 32'(in_ready), 32'(rdy_e));
    chk("mem_we", 32'(mem_we), 32'(we_e));
    chk("mem_addr", 32'(mem_addr), 32'(8'(m_base + m_words)));
    if (we_e) chk("mem_wdata", 32'(mem_wdata), 32'(exp_q[0].data));
    chk("status", 32'({busy, done, err_illegal, err_full}),
        32'({m_load || m_full, m_done, m_ei, m_ef}));
    chk("words", 32'(words), 32'(m_words));
    if (prev_stall) begin
      chk("stall_addr", 32'(mem_addr), 32'(prev_addr));
      chk("stall_data", 32'(mem_wdata), 32'(prev_data));
    end
    prev_stall = mem_we && !mem_ready && !start && !reset;
    prev_addr  = mem_addr;
    prev_data  = mem_wdata;
    if (mem_we && mem_ready) begin
      last_wr_addr = mem_addr;
      last_wr_data = mem_wdata;
    end
    wr  = we_e && mem_ready;
    acc = in_valid && rdy_e;
    if (reset) begin
      m_load = 0; m_done = 0; m_full = 0; m_ei = 0; m_ef = 0;
      m_words = 0; m_legal = 0; m_base = 8'h00; exp_q.delete();
    end else if (start) begin
      m_load = 1; m_done = 0; m_full = 0; m_ei = 0; m_ef = 0;
      m_words = 0; m_legal = 0; m_base = base_addr; exp_q.delete();
    end else if (m_load) begin
      go_done = 0;
      go_full = 0;
      if (wr) begin
        f = exp_q.pop_front();
        m_words++;
        if (f.last) go_done = 1;
        else if (m_words == CAP) go_full = 1;
      end
      if (acc) begin
        if (is_illegal(int'(in_kind), int'(in_sub))) begin
          m_ei = 1;
          if (in_last) go_done = 1;
        end else if (m_legal == CAP) begin
          m_ef = 1;
        end else begin
          exp_q.push_back('{addr: 8'(m_base + m_legal),
                            data: model_word(int'(in_kind), int'(in_sub), int'(in_arg)),
                            last: in_last});
          m_legal++;
        end
      end
      if (go_done) begin m_load = 0; m_done = 1; end
      else if (go_full) begin m_load = 0; m_full = 1; end
    end else if (m_full && in_valid) begin
      m_ef = 1;
    end
  end

  always @(negedge clk) if (s_mem_we && s_mem_ready) s_addrs.push_back(s_mem_addr);

  always @(posedge clk) begin
    #1;
    if (rnd) mem_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pulse_start(input logic [7:0] b);
    start = 1'b1;
    base_addr = b;
    tick(1);
    start = 1'b0;
  endtask

  task automatic send(input int k, input int s, input int a, input bit last, output int n);
    bit got;
    in_kind = 4'(k); in_sub = 4'(s); in_arg = 3'(a); in_last = last; in_valid = 1'b1;
    got = 0;
    n = 0;
    while (!got && n < 200) begin
      @(negedge clk);
      got = in_ready;
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (!got) chk("send_timeout", 32'(0), 32'(1));
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin : main
    int  n, nreq, k, t;
    bit  got;
    reset = 1'b1; start = 1'b0; base_addr = 8'h00; in_valid = 1'b0; in_last = 1'b0;
    in_kind = 4'd0; in_sub = 4'd0; in_arg = 3'd0; mem_ready = 1'b1;
    s_start = 1'b0; s_base = 2'd0; s_in_valid = 1'b0; s_in_last = 1'b0;
    s_in_kind = 4'd0; s_in_sub = 4'd0; s_in_arg = 3'd0; s_mem_ready = 1'b1;

    chk("pin_sgr", 32'(model_word(0, 3, 5)), 32'(9'b000011_101));
    chk("pin_lwr", 32'(model_op(1, 0)), 32'(6'b001000));
    chk("pin_j", 32'(model_op(9, 7)), 32'(6'b111111));
    chk("pin_brci", 32'(model_op(5, 8)), 32'(6'b011101));
    chk("pin_si_ill", 32'(is_illegal(4, 5)), 32'(1));
    chk("pin_si_ok", 32'(model_op(4, 4)), 32'(6'b010100));

    tick(2);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_flags", 32'({in_ready, mem_we, busy, done, err_illegal, err_full}), 32'(0));
    chk("rst_words", 32'(words), 32'(0));
    chk("rst_addr", 32'(mem_addr), 32'(0));
    tick(1);

    // T1: single SGR
    pulse_start(8'h10);
    send(0, 3, 5, 0, n);
    @(negedge clk);
    chk("t1_we", 32'(mem_we), 32'(1));
    chk("t1_addr", 32'(mem_addr), 32'(8'h10));
    chk("t1_data", 32'(mem_wdata), 32'(9'b000011_101));
    tick(2);

    // T2: back-to-back stream
    pulse_start(8'h10);
    send(1, 0, 0, 0, n); chk("t2_acc0", 32'(n), 32'(1));
    send(2, 0, 0, 0, n); chk("t2_acc1", 32'(n), 32'(1));
    send(3, 0, 0, 0, n); chk("t2_acc2", 32'(n), 32'(1));
    send(9, 7, 0, 0, n); chk("t2_acc3", 32'(n), 32'(1));
    tick(2);
    @(negedge clk);
    chk("t2_words", 32'(words), 32'(4));
    chk("t2_last_addr", 32'(last_wr_addr), 32'(8'h13));
    chk("t2_last_data", 32'(last_wr_data), 32'(9'b111111_000));
    tick(1);

    // T3: illegal SI, then BRCI
    send(4, 5, 1, 0, n);
    @(negedge clk);
    chk("t3_err_ill", 32'(err_illegal), 32'(1));
    chk("t3_no_we", 32'(mem_we), 32'(0));
    chk("t3_words", 32'(words), 32'(4));
    tick(1);
    send(5, 8, 3, 0, n);
    tick(2);
    @(negedge clk);
    chk("t3_brci", 32'(last_wr_data), 32'(9'b011101_011));
    chk("t3_words2", 32'(words), 32'(5));
    tick(1);

    // T4: three-cycle memory stall mid-stream
    fork
      begin
        send(6, 2, 1, 0, n);
        send(7, 3, 2, 0, n);
        send(8, 1, 3, 0, n);
        send(0, 7, 4, 0, n);
      end
      begin
        tick(1);
        mem_ready = 1'b0;
        tick(3);
        mem_ready = 1'b1;
      end
    join
    tick(3);
    @(negedge clk);
    chk("t4_words", 32'(words), 32'(9));
    chk("t4_last", 32'(last_wr_data), 32'(9'b000111_100));
    tick(1);

    // T6: in_last on third request, then reset while loading
    pulse_start(8'h40);
    send(6, 1, 1, 0, n);
    send(7, 2, 2, 0, n);
    send(8, 3, 3, 1, n);
    @(negedge clk);
    chk("t6_not_yet", 32'(done), 32'(0));
    tick(1);
    @(negedge clk);
    chk("t6_done", 32'(done), 32'(1));
    chk("t6_busy", 32'(busy), 32'(0));
    chk("t6_words", 32'(words), 32'(3));
    tick(1);
    pulse_start(8'h20);
    send(0, 1, 1, 0, n);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    @(negedge clk);
    chk("t6_rst_flags", 32'({in_ready, mem_we, busy, done, err_illegal, err_full}), 32'(0));
    chk("t6_rst_words", 32'(words), 32'(0));
    chk("t6_rst_data", 32'(mem_wdata), 32'(0));
    tick(1);

    // T5: 4-word memory wraps, then fills
    s_start = 1'b1; s_base = 2'd2;
    tick(1);
    s_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      s_in_valid = 1'b1; s_in_kind = 4'd0; s_in_sub = 4'(i); s_in_arg = 3'(i);
      got = 0;
      t = 0;
      while (!got && t < 20) begin
        @(negedge clk);
        got = s_in_ready;
        @(posedge clk); #1;
        t++;
      end
      if (!got) chk("t5_timeout", 32'(0), 32'(1));
    end
    s_in_valid = 1'b0;
    @(negedge clk);
    chk("t5_busy", 32'(s_busy), 32'(1));
    chk("t5_done", 32'(s_done), 32'(0));
    chk("t5_err_full", 32'(s_err_full), 32'(1));
    chk("t5_words", 32'(s_words), 32'(4));
    chk("t5_ready", 32'(s_in_ready), 32'(0));
    chk("t5_nwr", 32'(s_addrs.size()), 32'(4));
    if (s_addrs.size() == 4) begin
      chk("t5_a0", 32'(s_addrs[0]), 32'(2));
      chk("t5_a1", 32'(s_addrs[1]), 32'(3));
      chk("t5_a2", 32'(s_addrs[2]), 32'(0));
      chk("t5_a3", 32'(s_addrs[3]), 32'(1));
    end
    tick(1);

    // Randomized programs with random memory backpressure
    rnd = 1;
    for (int p = 0; p < 12; p++) begin
      pulse_start(8'($urandom));
      nreq = $urandom_range(1, 12);
      for (int i = 0; i < nreq; i++) begin
        k = ($urandom_range(0, 3) == 0) ? $urandom_range(10, 15) : $urandom_range(0, 9);
        send(k, $urandom_range(0, 15), $urandom_range(0, 7), i == nreq - 1, n);
        if ($urandom_range(0, 3) == 0) tick(1);
        if (p == 5 && i == 2) pulse_start(8'hfe);
      end
      got = 0;
      t = 0;
      while (!got && t < 200) begin
        @(negedge clk);
        got = done;
        @(posedge clk); #1;
        t++;
      end
      chk("rnd_done", 32'(got), 32'(1));
    end
    rnd = 0;
    mem_ready = 1'b1;
    tick(3);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
